// File: rtl/div_unit.sv
// Iterative restoring divider (one quotient bit per cycle) producing {remainder, quotient}.
// Signed DIV support is compiled in only when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall_div
);

   // state  | meaning
   // S_IDLE | waiting for start; a zero divisor goes straight to S_DONE
   // S_BUSY | one restoring iteration per cycle, cnt_q counts 0..WIDTH-1
   // S_DONE | result valid, ready high for this single cycle
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam int CW = 6;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH:0]     rem_sh, trial;
   logic [WIDTH-1:0]   rem_nx, quot_nx;
   logic [WIDTH-1:0]   abs_a, abs_b, rem_fix, quot_fix;

   assign rem_sh = {rem_q, quot_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};
   assign rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIV_SIGNED_EN
   logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic sgn_a, sgn_b;
   assign sgn_a    = signed_div & a[WIDTH-1];
   assign sgn_b    = signed_div & b[WIDTH-1];
   assign abs_a    = sgn_a ? -a : a;
   assign abs_b    = sgn_b ? -b : b;
   assign quot_fix = neg_q_q ? -quot_nx : quot_nx;
   assign rem_fix  = neg_r_q ? -rem_nx : rem_nx;
`else
   logic unused_signed_div;
   assign unused_signed_div = signed_div;
   assign abs_a    = a;
   assign abs_b    = b;
   assign quot_fix = quot_nx;
   assign rem_fix  = rem_nx;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      dvs_d    = dvs_q;
      result_d = result_q;
`ifdef DIV_SIGNED_EN
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !annul) begin
               if (b != '0) begin
                  state_d = S_BUSY;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quot_d  = abs_a;
                  dvs_d   = abs_b;
`ifdef DIV_SIGNED_EN
                  neg_q_d = sgn_a ^ sgn_b;
                  neg_r_d = sgn_a;
`endif
               end else begin
                  // Divide by zero: raw dividend as remainder, no sign fix-up
                  state_d  = S_DONE;
                  result_d = {a, {WIDTH{1'b1}}};
               end
            end
         end
         S_BUSY: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               rem_d  = rem_nx;
               quot_d = quot_nx;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d  = S_DONE;
                  result_d = {rem_fix, quot_fix};
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvs_q    <= '0;
         result_q <= '0;
`ifdef DIV_SIGNED_EN
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
`ifdef DIV_SIGNED_EN
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
`endif
      end
   end

   assign result    = result_q;
   assign ready     = (state_q == S_DONE);
   assign stall_div = ((state_q == S_IDLE) && start && !annul) || (state_q == S_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; signed expectations follow DIV_SIGNED_EN.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic [31:0] a;
   logic [31:0] b;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stall_div;

   int checks = 0;
   int errors = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .a          (a),
      .b          (b),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stall_div  (stall_div)
   );

   always #5 clk = ~clk;

   // Called at a falling edge; start is held until the ready cycle (inclusive),
   // then dropped. Returns at the falling edge of the cycle after ready.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                        output int rdy_cyc, output int stall_cnt);
      start = 1'b1; a = av; b = bv; signed_div = sg;
      rdy_cyc = -1; stall_cnt = 0;
      for (int c = 0; c < 40 && rdy_cyc < 0; c++) begin
         #1;
         if (stall_div) stall_cnt++;
         if (ready) rdy_cyc = c;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (result !== 64'h0 || ready !== 1'b0 || stall_div !== 1'b0) begin
         errors++;
         $display("FAIL reset: result=%h ready=%b stall=%b required 0/0/0", result, ready, stall_div);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int rc, sc, extra;
      do_op(32'd100, 32'd7, 1'b0, rc, sc);
      checks++;
      if (rc !== 33) begin errors++; $display("FAIL unsigned_ready_cycle: got %0d required 33", rc); end
      checks++;
      if (sc !== 33) begin errors++; $display("FAIL unsigned_stall_cycles: got %0d required 33", sc); end
      checks++;
      if (result !== {32'h2, 32'hE}) begin
         errors++; $display("FAIL unsigned_result: got %h required %h", result, {32'h2, 32'hE});
      end
      // start was held through DONE: no second operation may have begun
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (ready || stall_div) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL single_ready: %0d cycles with ready/stall after DONE, required 0", extra); end
   endtask

   task automatic test_signed();
      int rc, sc;
      logic [63:0] exp1, exp2;
`ifdef DIV_SIGNED_EN
      exp1 = {32'hFFFFFFFF, 32'hFFFFFFFD};
      exp2 = {32'h00000001, 32'hFFFFFFFD};
`else
      exp1 = {32'h00000001, 32'h7FFFFFFC};
      exp2 = {32'h00000007, 32'h00000000};
`endif
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, rc, sc);
      checks++;
      if (result !== exp1 || rc !== 33) begin
         errors++; $display("FAIL signed_neg7_by_2: got %h cyc %0d required %h cyc 33", result, rc, exp1);
      end
      do_op(32'd7, 32'hFFFFFFFE, 1'b1, rc, sc);
      checks++;
      if (result !== exp2 || rc !== 33) begin
         errors++; $display("FAIL signed_7_by_neg2: got %h cyc %0d required %h cyc 33", result, rc, exp2);
      end
   endtask

   task automatic test_div_zero();
      int rc, sc;
      do_op(32'h00001234, 32'h0, 1'b0, rc, sc);
      checks++;
      if (rc !== 1 || sc !== 1) begin
         errors++; $display("FAIL divzero_timing: ready cyc %0d stall %0d required 1/1", rc, sc);
      end
      checks++;
      if (result !== {32'h00001234, 32'hFFFFFFFF}) begin
         errors++; $display("FAIL divzero_result: got %h required %h", result, {32'h00001234, 32'hFFFFFFFF});
      end
      do_op(32'hFFFFFFF9, 32'h0, 1'b1, rc, sc);
      checks++;
      if (result !== {32'hFFFFFFF9, 32'hFFFFFFFF} || rc !== 1) begin
         errors++; $display("FAIL divzero_signed: got %h cyc %0d required %h cyc 1", result, rc, {32'hFFFFFFF9, 32'hFFFFFFFF});
      end
   endtask

   task automatic test_overflow();
      int rc, sc;
      logic [63:0] exp_s;
`ifdef DIV_SIGNED_EN
      exp_s = {32'h00000000, 32'h80000000};
`else
      exp_s = {32'h80000000, 32'h00000000};
`endif
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, rc, sc);
      checks++;
      if (result !== exp_s) begin errors++; $display("FAIL overflow_signed: got %h required %h", result, exp_s); end
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, rc, sc);
      checks++;
      if (result !== {32'h80000000, 32'h00000000}) begin
         errors++; $display("FAIL overflow_unsigned: got %h required %h", result, {32'h80000000, 32'h00000000});
      end
   endtask

   task automatic test_annul();
      logic [63:0] prev;
      int bad, rc, sc;
      prev = result;
      start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
      for (int c = 0; c < 11; c++) begin
         if (c == 10) annul = 1'b1;
         #1;
         if (c == 10) begin
            checks++;
            if (stall_div !== 1'b1) begin errors++; $display("FAIL annul_busy_stall: got %b required 1 in annul cycle", stall_div); end
         end
         @(negedge clk);
      end
      start = 1'b0; annul = 1'b0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (stall_div || ready) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL annul_quiet: %0d cycles with stall/ready, required 0", bad); end
      checks++;
      if (result !== prev) begin errors++; $display("FAIL annul_result_kept: got %h required %h", result, prev); end
      // annul in IDLE masks stall combinationally and starts nothing
      start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
      #1;
      checks++;
      if (stall_div !== 1'b0) begin errors++; $display("FAIL annul_idle_stall: got %b required 0", stall_div); end
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      #1;
      checks++;
      if (stall_div !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("FAIL annul_idle_nostart: stall %b ready %b required 0/0", stall_div, ready);
      end
      @(negedge clk);
      do_op(32'd9, 32'd3, 1'b0, rc, sc);
      checks++;
      if (result !== {32'h0, 32'h3} || rc !== 33) begin
         errors++; $display("FAIL after_annul_9_3: got %h cyc %0d required %h cyc 33", result, rc, {32'h0, 32'h3});
      end
   endtask

   task automatic test_back_to_back();
      int rc1, sc1, rc2, sc2;
      do_op(32'h12345678, 32'h00000100, 1'b0, rc1, sc1);
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, rc2, sc2);
      checks++;
      if (rc2 !== 33 || sc2 !== 33) begin
         errors++; $display("FAIL b2b_timing: ready cyc %0d stall %0d required 33/33", rc2, sc2);
      end
      checks++;
      if (result !== {32'h0, 32'hFFFFFFFF}) begin
         errors++; $display("FAIL b2b_result: got %h required %h", result, {32'h0, 32'hFFFFFFFF});
      end
      do_op(32'h12345678, 32'h00000100, 1'b0, rc1, sc1);
      checks++;
      if (result !== {32'h00000078, 32'h00123456}) begin
         errors++; $display("FAIL shift_div: got %h required %h", result, {32'h00000078, 32'h00123456});
      end
   endtask

   task automatic test_rst_busy();
      start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (result !== 64'h0 || ready !== 1'b0 || stall_div !== 1'b0) begin
         errors++; $display("FAIL rst_busy: result=%h ready=%b stall=%b required 0/0/0", result, ready, stall_div);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (stall_div !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("FAIL rst_discard: stall %b ready %b required 0/0", stall_div, ready);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_annul();
      test_back_to_back();
      test_rst_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the EX stage, executing DIV/DIVU and producing the {HI, LO} pair that the HI/LO register writes in MEM/WB. It sits directly upstream of the hazard unit: while a division is in flight it raises `stall_div`, which the hazard unit ORs into `stallF`/`stallD` and into the EX-stage freeze. A separate `annul` input drops an in-flight operation when the owning instruction is flushed. Restoring algorithm, one quotient bit per cycle.

## Interface
- `WIDTH`, default 32: operand width; the result is 2*WIDTH.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  DIV/DIVU is in EX; held high by the pipeline for as long as the instruction stays in EX.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start`.
- `a`  in  WIDTH  dividend (forwarded rs value); sampled with `start`.
- `b`  in  WIDTH  divisor (forwarded rt value); sampled with `start`.
- `annul`  in  1  abort the current operation (EX flush or exception).
- `result`  out  2*WIDTH  {remainder, quotient}: [63:32] goes to HI, [31:0] goes to LO.
- `ready`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `stall_div`  out  1  request to the hazard unit to freeze F/D/E.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - `start & ~annul & b!=0`: latch |a|, |b| and the sign flags, clear the remainder and the 6-bit counter, and go to BUSY.
  - `start & ~annul & b==0`: go to DONE and load the zero-divide result.
- **BUSY**
  - Each cycle: shift {rem, quot} left by 1. Trial-subtract the divisor from rem (WIDTH+1 bits). If the result is non-negative, keep it and set quot[0]=1.
  - After WIDTH iterations (counter reaches WIDTH-1), apply the sign fix-up, load `result`, and go to DONE.
  - `start` is ignored while in BUSY.
- **DONE**
  - `ready=1` for exactly this cycle, then return to IDLE.
  - `start` is ignored in DONE, because the same instruction is still in EX for this cycle.
- **Sign fix-up (signed mode)**
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of a.
  - Arithmetic is two's complement modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **Divide by zero:** quotient = all ones, remainder = a (raw a, no sign fix-up), in both modes.
- **`annul`:** in IDLE or BUSY, return to IDLE at the next edge. No `ready`; `result` keeps its previous value. Ignored in DONE.
- **`result`** holds its value from DONE until the next completed operation.
- **`rst`:** state=IDLE, counter=0, `result`=0, `ready`=0, `stall_div`=0. A reset during BUSY discards the operation.

## Timing
- `stall_div` is combinational: `(IDLE & start & ~annul) | BUSY`. It is low in DONE, so the instruction leaves EX in the cycle `result` is valid, and EX/MEM captures `result`.
- Normal latency: `start` is seen in IDLE at cycle 0. BUSY occupies cycles 1..32. DONE and `ready` occur at cycle 33. `stall_div` is high for cycles 0..32 (33 cycles).
- Zero divisor: `stall_div` is high in cycle 0 only; DONE and `ready` occur at cycle 1.
- Back-to-back divisions: the earliest next start is cycle 34, i.e. IDLE in the cycle after DONE.
- `annul` in cycle k: `stall_div` drops combinationally in cycle k if the block is in IDLE; otherwise it drops at cycle k+1.
- Outputs `result` and `ready` are registered. `stall_div` is the only combinational output.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: `signed_div` selects signed operation; the abs/negate logic is present.
  - Undefined: `signed_div` is ignored, DIV executes as unsigned, and the negation logic is compiled out. Latency is unchanged.

## Test plan
- Unsigned: a=100, b=7, signed_div=0. Required: `stall_div` high for 33 cycles, `ready` at cycle 33, `result`={0x00000002, 0x0000000E}.
- Signed (`DIV_SIGNED_EN`): a=0xFFFFFFF9 (-7), b=2. Required: `result`={0xFFFFFFFF, 0xFFFFFFFD}. With the macro undefined: `result`={0x00000001, 0x7FFFFFFC}.
- Divide by zero: a=0x00001234, b=0. Required: `ready` at cycle 1 and `result`={0x00001234, 0xFFFFFFFF}.
- Overflow corner: a=0x80000000, b=0xFFFFFFFF.
  - Signed: `result`={0x00000000, 0x80000000}.
  - Unsigned: `result`={0x80000000, 0x00000000}.
- Annul and reset: assert `annul` at cycle 10 of 100/7. Required: `stall_div` low from cycle 11, no `ready`, `result` unchanged. A following start of 9/3 gives {0, 3}. A `rst` pulse at cycle 20 of a further run gives all outputs 0 on the next cycle.
- `start` held through DONE: after `ready`, keep `start`=1 for one more cycle. Required: exactly one `ready` pulse and no new operation.
